// File: rtl/mc_ctrl.sv
// Multicycle MIPS main controller: steps the shared datapath through fetch/decode/execute.
// Define MC_CTRL_LOGIC_IMM_EN to also decode andi/ori/slti as immediate ALU instructions.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       pcwrite,
    output logic       branch,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       illegal,
    output logic       done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StImmEx   = 4'd9,
        StImmWb   = 4'd10,
        StJEx     = 4'd11
    } state_e;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;

    state_e     r_state;
    state_e     w_state_next;
    logic       w_imm_op;
    logic [2:0] w_imm_aluop;

`ifdef MC_CTRL_LOGIC_IMM_EN
    always_comb begin
        w_imm_op    = 1'b1;
        w_imm_aluop = 3'b000;
        case (op)
            OpAddi:  w_imm_aluop = 3'b000;
            OpAndi:  w_imm_aluop = 3'b100;
            OpOri:   w_imm_aluop = 3'b101;
            OpSlti:  w_imm_aluop = 3'b110;
            default: w_imm_op    = 1'b0;
        endcase
    end
`else
    always_comb begin
        w_imm_op    = (op == OpAddi);
        w_imm_aluop = 3'b000;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        iord         = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        regwrite     = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = 3'b000;
        illegal      = 1'b0;
        done         = 1'b0;

        case (r_state)
            StFetch: begin
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
                if (memready) w_state_next = StDecode;
            end
            StDecode: begin
                // Branch target is precomputed here while the opcode is decoded.
                alusrcb = 2'b11;
                if (op == OpLw || op == OpSw) begin
                    w_state_next = StMemAdr;
                end else if (op == OpRtype) begin
                    w_state_next = StRtypeEx;
                end else if (op == OpBeq) begin
                    w_state_next = StBeqEx;
                end else if (w_imm_op) begin
                    w_state_next = StImmEx;
                end else if (op == OpJ) begin
                    w_state_next = StJEx;
                end else begin
                    illegal      = 1'b1;
                    done         = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StMemAdr: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                w_state_next = (op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord = 1'b1;
                if (memready) w_state_next = StMemWb;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (memready) begin
                    done         = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StMemWb: begin
                regwrite     = 1'b1;
                memtoreg     = 1'b1;
                done         = 1'b1;
                w_state_next = StFetch;
            end
            StRtypeEx: begin
                alusrca      = 1'b1;
                aluop        = 3'b010;
                w_state_next = StRtypeWb;
            end
            StRtypeWb: begin
                regwrite     = 1'b1;
                regdst       = 1'b1;
                done         = 1'b1;
                w_state_next = StFetch;
            end
            StBeqEx: begin
                alusrca      = 1'b1;
                aluop        = 3'b001;
                branch       = 1'b1;
                pcsrc        = 2'b01;
                done         = 1'b1;
                w_state_next = StFetch;
            end
            StImmEx: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                aluop        = w_imm_aluop;
                w_state_next = StImmWb;
            end
            StImmWb: begin
                regwrite     = 1'b1;
                done         = 1'b1;
                w_state_next = StFetch;
            end
            StJEx: begin
                pcwrite      = 1'b1;
                pcsrc        = 2'b10;
                done         = 1'b1;
                w_state_next = StFetch;
            end
            default: w_state_next = StFetch;
        endcase

        // Abandon any in-flight instruction without touching architectural state.
        if (reset) begin
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            illegal  = 1'b0;
            done     = 1'b0;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: builds each instruction's expected cycle trace from the
// per-instruction-class rules and compares every control output once per cycle.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal;
        logic       done;
        logic [3:0] state;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       memready;
    ctl_t       got;

    int n_vec = 0;
    int n_err = 0;

    string tag_q[$];
    logic  mr_q[$];
    ctl_t  exp_q[$];

    mc_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .memready (memready),
        .pcwrite  (got.pcwrite),
        .branch   (got.branch),
        .iord     (got.iord),
        .memwrite (got.memwrite),
        .irwrite  (got.irwrite),
        .regwrite (got.regwrite),
        .regdst   (got.regdst),
        .memtoreg (got.memtoreg),
        .alusrca  (got.alusrca),
        .alusrcb  (got.alusrcb),
        .pcsrc    (got.pcsrc),
        .aluop    (got.aluop),
        .illegal  (got.illegal),
        .done     (got.done),
        .state    (got.state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle: apply memready, compare outputs mid-cycle, advance past the next edge.
    task automatic step(input string tag, input logic mr, input ctl_t e);
        memready = mr;
        @(negedge clk);
        check(tag, 32'(got), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string tag, input logic mr, input ctl_t c);
        tag_q.push_back(tag);
        mr_q.push_back(mr);
        exp_q.push_back(c);
    endtask

    function automatic ctl_t blank(input int st);
        ctl_t c;
        c = '0;
        c.state = 4'(st);
        return c;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction class: 0 lw,1 sw,2 R,3 beq,4 imm,5 j,6 illegal; aluop for imm.
    function automatic int classify(input logic [5:0] o, output logic [2:0] imm_alu);
        imm_alu = 3'b000;
        if (o == 6'b100011) return 0;
        if (o == 6'b101011) return 1;
        if (o == 6'b000000) return 2;
        if (o == 6'b000100) return 3;
        if (o == 6'b001000) return 4;
        if (o == 6'b000010) return 5;
`ifdef MC_CTRL_LOGIC_IMM_EN
        if (o == 6'b001100) begin imm_alu = 3'b100; return 4; end
        if (o == 6'b001101) begin imm_alu = 3'b101; return 4; end
        if (o == 6'b001010) begin imm_alu = 3'b110; return 4; end
`endif
        return 6;
    endfunction

    task automatic build(input logic [5:0] o, input int nf, input int nm);
        ctl_t c;
        logic [2:0] ia;
        int cls;
        cls = classify(o, ia);
        for (int i = 0; i < nf; i++) begin
            c = blank(0); c.alusrcb = 2'b01;
            add("fetch_stall", 1'b0, c);
        end
        c = blank(0); c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1;
        add("fetch", 1'b1, c);
        c = blank(1); c.alusrcb = 2'b11;
        if (cls == 6) begin c.illegal = 1'b1; c.done = 1'b1; end
        add("decode", rnd_bit(), c);
        case (cls)
            0, 1: begin
                c = blank(2); c.alusrca = 1'b1; c.alusrcb = 2'b10;
                add("memadr", rnd_bit(), c);
                for (int i = 0; i <= nm; i++) begin
                    if (cls == 0) begin
                        c = blank(3); c.iord = 1'b1;
                        add("memrd", (i == nm), c);
                    end else begin
                        c = blank(5); c.iord = 1'b1; c.memwrite = 1'b1; c.done = (i == nm);
                        add("memwr", (i == nm), c);
                    end
                end
                if (cls == 0) begin
                    c = blank(4); c.regwrite = 1'b1; c.memtoreg = 1'b1; c.done = 1'b1;
                    add("memwb", rnd_bit(), c);
                end
            end
            2: begin
                c = blank(6); c.alusrca = 1'b1; c.aluop = 3'b010;
                add("rtypeex", rnd_bit(), c);
                c = blank(7); c.regwrite = 1'b1; c.regdst = 1'b1; c.done = 1'b1;
                add("rtypewb", rnd_bit(), c);
            end
            3: begin
                c = blank(8); c.alusrca = 1'b1; c.aluop = 3'b001; c.branch = 1'b1;
                c.pcsrc = 2'b01; c.done = 1'b1;
                add("beqex", rnd_bit(), c);
            end
            4: begin
                c = blank(9); c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = ia;
                add("immex", rnd_bit(), c);
                c = blank(10); c.regwrite = 1'b1; c.done = 1'b1;
                add("immwb", rnd_bit(), c);
            end
            5: begin
                c = blank(11); c.pcwrite = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1;
                add("jex", rnd_bit(), c);
            end
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [5:0] o, input int nf, input int nm);
        int latency;
        int n_done;
        build(o, nf, nm);
        latency = 0;
        n_done  = 0;
        op      = o;
        while (exp_q.size() > 0) begin
            if (exp_q[0].done) n_done++;
            step(tag_q.pop_front(), mr_q.pop_front(), exp_q.pop_front());
            latency++;
        end
        check("done_once", 32'(n_done), 32'd1);
        if (latency > 64) check("latency_bound", 32'(latency), 32'd64);
    endtask

    // Reset asserted for two cycles while an lw sits in MEMRD.
    task automatic reset_mid_lw();
        ctl_t c;
        logic [3:0] strobes;
        op = 6'b100011;
        c = blank(0); c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1;
        step("rst_fetch", 1'b1, c);
        c = blank(1); c.alusrcb = 2'b11;
        step("rst_decode", 1'b1, c);
        c = blank(2); c.alusrca = 1'b1; c.alusrcb = 2'b10;
        step("rst_memadr", 1'b1, c);
        reset    = 1'b1;
        memready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            strobes = {got.regwrite, got.memwrite, got.done, got.irwrite | got.pcwrite};
            check("rst_strobes", 32'(strobes), 32'd0);
            check("rst_state", 32'(got.state), (i == 0) ? 32'd3 : 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        c = blank(0); c.alusrcb = 2'b01;
        step("rst_after", 1'b0, c);
    endtask

    initial begin
        ctl_t c;
        logic [5:0] o;
        int sel;
        reset    = 1'b1;
        op       = 6'b000000;
        memready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        c = blank(0); c.alusrcb = 2'b01;
        step("reset_state", 1'b0, c);

        reset_mid_lw();
        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 0, 3);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b001101, 0, 0);
        run_instr(6'b000010, 2, 0);

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 10));
            case (sel)
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                6: o = 6'b001100;
                7: o = 6'b001101;
                8: o = 6'b001010;
                default: o = 6'($urandom_range(0, 63));
            endcase
            run_instr(o, int'($urandom_range(0, 3)) * int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)));
            if (n % 80 == 79) reset_mid_lw();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle main controller for the MIPS core. Decodes the opcode held in the instruction register and steps the shared datapath through fetch, decode, execute, memory and writeback cycles. Drives the mux selects, the write strobes and the 3-bit `aluop` consumed by the ALU decoder, so one ALU serves PC increment, branch target, address generation and execute. Supports memory wait-states through a single `memready` handshake.

## Interface
Parameters: none.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instruction opcode from IR; stable from DECODE until the next FETCH completes.
- `memready` in 1: unified memory completes the current access this cycle.
- `pcwrite` out 1: unconditional PC load.
- `branch` out 1: PC load qualified by ALU zero; datapath forms `pcen = pcwrite | (branch & zero)`.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: IR load.
- `regwrite` out 1: register file write.
- `regdst` out 1: destination select (1 = rd, 0 = rt).
- `memtoreg` out 1: writeback select (1 = MDR, 0 = ALUOut).
- `alusrca` out 1: ALU A select (0 = PC, 1 = reg A).
- `alusrcb` out 2: ALU B select (00 = reg B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2).
- `pcsrc` out 2: PC source (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `aluop` out 3: 000 add, 001 sub, 010 R-type (use funct), 100 and, 101 or, 110 slt.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `done` out 1: high in the last cycle of every instruction.
- `state` out 4: current state encoding, for debug.

## Operation
- State register, 4 bits. Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11. Encodings 12–15 are unreachable and go to FETCH.
- Outputs are decoded from the state, plus `memready` in the memory states. Any output not listed for a state is 0.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00.
  - irwrite = pcwrite = memready.
  - Advance to DECODE only when memready=1; otherwise hold.
- DECODE: alusrca=0, alusrcb=11, aluop=000 (precompute branch target). Next state by op:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 → RTYPEEX
  - beq 000100 → BEQEX
  - addi 001000 → IMMEX
  - j 000010 → JEX
  - anything else → FETCH with illegal=1 and done=1
- MEMADR: alusrca=1, alusrcb=10, aluop=000. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1. Advance to MEMWB when memready=1; otherwise hold.
- MEMWR: iord=1, memwrite=1. Hold until memready=1; that cycle asserts done and returns to FETCH.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, done=1. Next FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=010. Next RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0, done=1. Next FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=001, branch=1, pcsrc=01, done=1. Next FETCH.
- IMMEX: alusrca=1, alusrcb=10. aluop by op: addi 000, andi 100, ori 101, slti 110. Next IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0, done=1. Next FETCH.
- JEX: pcwrite=1, pcsrc=10, done=1. Next FETCH.

## Timing
- Reset:
  - On any edge with reset=1, state ← FETCH, including mid-instruction. The partial instruction is abandoned with no further writes.
  - While reset=1, memwrite, irwrite, regwrite, pcwrite, branch, illegal and done are forced to 0.
- After reset, outputs equal the FETCH decode: alusrcb=01, all others 0, irwrite/pcwrite = memready.
- Latency with memready tied to 1: lw 5 cycles, sw 4, R-type 4, addi/andi/ori/slti 4, beq 3, j 3, illegal 2.
- Each cycle memready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes stay valid throughout the stall.
- memready is ignored in all other states.

## Configuration
- `MC_CTRL_LOGIC_IMM_EN` defined: andi 001100, ori 001101 and slti 001010 decode to IMMEX with aluop 100, 101 and 110 respectively.
- Undefined: those three opcodes are illegal (DECODE → FETCH, illegal pulse). addi is unaffected.

## Test plan
- Reset held 2 cycles during MEMRD, memready=1 → state=0 on the cycle after reset drops; regwrite never asserted; alusrcb=01.
- lw (op=100011), memready=1 → states 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; done high exactly once.
- sw with memready=0 for 3 cycles in MEMWR → memwrite high 4 consecutive cycles; done only in the 4th; total 7 cycles.
- R-type then beq → aluop=010 in state 6; regdst=1 in state 7; aluop=001, branch=1, pcsrc=01 in state 8.
- op=001101 → with the macro, state 9 with aluop=101 then state 10 regwrite=1; without it, illegal=1 in DECODE, then state=0.
- j (op=000010) → state 11 with pcwrite=1, pcsrc=10; FETCH stalled 2 cycles by memready=0 → irwrite low, state holds 0.
